// File: rtl/fetch_unit.sv
// Instruction fetch datapath: owns the PC, reads instruction words from ROM over a
// req/ack handshake, and decodes opcode/register fields plus the 2-word immediate.
module fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              CS_PC_load,
    input  logic              CS_PC_inc,
    input  logic              CS_Ins_load,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        opcode,
    output logic [2:0]        op1_addr,
    output logic [2:0]        op2_addr,
    output logic [DATA_W-1:0] imm,
    output logic              two_byte,
    output logic              ins_valid,
    output logic              busy,
    output logic              err_overrun,
    output logic              err_timeout
);
    // ROM handshake: rom_req rises one cycle after CS_Ins_load and holds with a stable
    // rom_addr until a cycle where rom_ack=1 is sampled; that cycle also carries rom_data.
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [ADDR_W-1:0] fetch_addr;
    logic              phase;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            fetch_addr  <= '0;
            phase       <= 1'b0;
            pc          <= '0;
            rom_req     <= 1'b0;
            rom_addr    <= '0;
            opcode      <= '0;
            op1_addr    <= '0;
            op2_addr    <= '0;
            imm         <= '0;
            two_byte    <= 1'b0;
            ins_valid   <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else if (!en) begin
            // Abort: drop any outstanding request and forget a half-fetched 2-word insn.
            state     <= S_IDLE;
            timer     <= '0;
            phase     <= 1'b0;
            rom_req   <= 1'b0;
            two_byte  <= 1'b0;
            ins_valid <= 1'b0;
        end else begin
            ins_valid <= 1'b0;
            if (CS_PC_inc)
                pc <= pc + ADDR_W'(1);
            if (CS_PC_load)
                fetch_addr <= pc;

            case (state)
                S_IDLE: begin
                    if (CS_Ins_load) begin
                        rom_addr <= fetch_addr;
                        rom_req  <= 1'b1;
                        timer    <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (CS_Ins_load)
                        err_overrun <= 1'b1;
                    if (rom_ack) begin
                        rom_req   <= 1'b0;
                        ins_valid <= 1'b1;
                        state     <= S_DONE;
                        if (!phase) begin
                            opcode   <= rom_data[15:12];
                            op1_addr <= rom_data[11:9];
                            op2_addr <= rom_data[8:6];
                            // MVI (1100) and LDA (1101) carry a second immediate word.
                            if (rom_data[15:13] == 3'b110) begin
                                phase    <= 1'b1;
                                two_byte <= 1'b1;
                            end
                        end else begin
                            imm      <= rom_data;
                            phase    <= 1'b0;
                            two_byte <= 1'b0;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        // Request has been high for TIMEOUT cycles: give up.
                        rom_req     <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DONE: begin
                    if (CS_Ins_load)
                        err_overrun <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven decode and PC vectors plus hand-written
// sequences for timeout, overrun, enable abort and asynchronous reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, en, CS_PC_load, CS_PC_inc, CS_Ins_load;
    logic        rom_req, rom_ack;
    logic [7:0]  rom_addr, pc;
    logic [15:0] rom_data, imm;
    logic [3:0]  opcode;
    logic [2:0]  op1_addr, op2_addr;
    logic        two_byte, ins_valid, busy, err_overrun, err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .CS_PC_load(CS_PC_load), .CS_PC_inc(CS_PC_inc), .CS_Ins_load(CS_Ins_load),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ack(rom_ack),
        .pc(pc), .opcode(opcode), .op1_addr(op1_addr), .op2_addr(op2_addr), .imm(imm),
        .two_byte(two_byte), .ins_valid(ins_valid), .busy(busy),
        .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  opc;
        logic [2:0]  op1;
        logic [2:0]  op2;
        logic        tb;
        logic [15:0] imm;
    } dec_vec_t;

    typedef struct {
        logic       inc;
        logic       load;
        logic [7:0] exp_pc;
    } pc_vec_t;

    dec_vec_t dec_tab[8];
    pc_vec_t  pc_tab[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int wait_cyc, input logic [15:0] word,
                            input logic [7:0] exp_addr, input string tag);
        CS_Ins_load = 1'b1;
        step();
        CS_Ins_load = 1'b0;
        check({tag, "_req"}, rom_req, 1);
        check({tag, "_addr"}, rom_addr, exp_addr);
        repeat (wait_cyc) step();
        check({tag, "_req_hold"}, rom_req, 1);
        check({tag, "_no_early_valid"}, ins_valid, 0);
        rom_ack  = 1'b1;
        rom_data = word;
        step();
        rom_ack  = 1'b0;
        rom_data = 16'h0;
        check({tag, "_valid"}, ins_valid, 1);
        check({tag, "_req_drop"}, rom_req, 0);
        step();
        check({tag, "_valid_pulse"}, ins_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_dec(input string tag, input logic [3:0] opc, input logic [2:0] o1,
                             input logic [2:0] o2, input logic tb, input logic [15:0] im);
        check({tag, "_opcode"}, opcode, opc);
        check({tag, "_op1"}, op1_addr, o1);
        check({tag, "_op2"}, op2_addr, o2);
        check({tag, "_two_byte"}, two_byte, tb);
        check({tag, "_imm"}, imm, im);
    endtask

    initial begin : main
        int cnt;
        logic saw_valid;

        dec_tab[0] = '{16'h0A40, 4'h0, 3'd5, 3'd1, 1'b0, 16'h00AB};
        dec_tab[1] = '{16'h3E80, 4'h3, 3'd7, 3'd2, 1'b0, 16'h00AB};
        dec_tab[2] = '{16'hC200, 4'hC, 3'd1, 3'd0, 1'b1, 16'h00AB};
        dec_tab[3] = '{16'h5555, 4'hC, 3'd1, 3'd0, 1'b0, 16'h5555};
        dec_tab[4] = '{16'hD5C0, 4'hD, 3'd2, 3'd7, 1'b1, 16'h5555};
        dec_tab[5] = '{16'h1234, 4'hD, 3'd2, 3'd7, 1'b0, 16'h1234};
        dec_tab[6] = '{16'hE000, 4'hE, 3'd0, 3'd0, 1'b0, 16'h1234};
        dec_tab[7] = '{16'hB1C0, 4'hB, 3'd0, 3'd7, 1'b0, 16'h1234};

        pc_tab[0] = '{1'b1, 1'b0, 8'd5};
        pc_tab[1] = '{1'b1, 1'b1, 8'd6};   // load sees pre-increment pc=5
        pc_tab[2] = '{1'b0, 1'b0, 8'd6};
        pc_tab[3] = '{1'b1, 1'b0, 8'd7};

        // Clock/reset
        rst_n = 1'b0; en = 1'b1; CS_PC_load = 1'b0; CS_PC_inc = 1'b0; CS_Ins_load = 1'b0;
        rom_ack = 1'b0; rom_data = 16'h0;
        repeat (3) step();
        check("rst_pc", pc, 0);
        check("rst_req", rom_req, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", ins_valid, 0);
        check_dec("rst", 4'h0, 3'd0, 3'd0, 1'b0, 16'h0);
        check("rst_errs", {err_overrun, err_timeout}, 0);
        #3 rst_n = 1'b1;
        step();

        // ADD r5,r1 at ROM[0]
        CS_PC_load = 1'b1; step(); CS_PC_load = 1'b0;
        do_fetch(2, 16'h0A40, 8'd0, "add");
        check_dec("add", 4'h0, 3'd5, 3'd1, 1'b0, 16'h0);
        CS_PC_inc = 1'b1; step(); CS_PC_inc = 1'b0;
        check("add_pc_inc", pc, 1);

        // MVI at ROM[3], immediate at ROM[4]
        CS_PC_inc = 1'b1; step(); step(); CS_PC_inc = 1'b0;
        check("mvi_pc", pc, 3);
        CS_PC_load = 1'b1; step(); CS_PC_load = 1'b0;
        do_fetch(1, 16'hC200, 8'd3, "mvi1");
        check_dec("mvi1", 4'hC, 3'd1, 3'd0, 1'b1, 16'h0);
        CS_PC_inc = 1'b1; step(); CS_PC_inc = 1'b0;
        CS_PC_load = 1'b1; step(); CS_PC_load = 1'b0;
        do_fetch(0, 16'h00AB, 8'd4, "mvi2");
        check_dec("mvi2", 4'hC, 3'd1, 3'd0, 1'b0, 16'h00AB);

        // Decode table, all fetched from fetch_addr=4
        for (int i = 0; i < 8; i++) begin
            do_fetch(i % 4, dec_tab[i].word, 8'd4, $sformatf("dec%0d", i));
            check_dec($sformatf("dec%0d", i), dec_tab[i].opc, dec_tab[i].op1,
                      dec_tab[i].op2, dec_tab[i].tb, dec_tab[i].imm);
        end

        // PC table including same-cycle load+inc
        for (int i = 0; i < 4; i++) begin
            CS_PC_inc = pc_tab[i].inc; CS_PC_load = pc_tab[i].load;
            step();
            CS_PC_inc = 1'b0; CS_PC_load = 1'b0;
            check($sformatf("pcvec%0d", i), pc, pc_tab[i].exp_pc);
        end
        do_fetch(0, 16'h0A40, 8'd5, "same_cycle");

        // en=0 holds pc and ignores strobes
        en = 1'b0; CS_PC_inc = 1'b1; CS_PC_load = 1'b1; step();
        en = 1'b1; CS_PC_inc = 1'b0; CS_PC_load = 1'b0;
        check("en0_pc_hold", pc, 7);

        // Wrap 0xFF -> 0x00
        CS_PC_inc = 1'b1; repeat (248) step(); CS_PC_inc = 1'b0;
        check("wrap_ff", pc, 8'hFF);
        CS_PC_inc = 1'b1; step(); CS_PC_inc = 1'b0;
        check("wrap_00", pc, 8'h00);

        // Timeout: ack never comes
        CS_Ins_load = 1'b1; step(); CS_Ins_load = 1'b0;
        cnt = 0; saw_valid = 1'b0;
        while (rom_req && cnt < 40) begin
            cnt++;
            step();
            if (ins_valid) saw_valid = 1'b1;
        end
        check("to_req_cycles", cnt, 15);
        check("to_err", err_timeout, 1);
        check("to_no_valid", saw_valid, 0);
        check("to_idle", busy, 0);
        do_fetch(3, 16'h3E80, 8'd5, "after_to");
        check_dec("after_to", 4'h3, 3'd7, 3'd2, 1'b0, 16'h1234);

        // Ack while idle is ignored
        rom_ack = 1'b1; rom_data = 16'hC000; step(); rom_ack = 1'b0; rom_data = 16'h0;
        check("idle_ack_valid", ins_valid, 0);
        check("idle_ack_opcode", opcode, 4'h3);

        // Overrun: second Ins_load during WAIT
        check("ovr_before", err_overrun, 0);
        CS_Ins_load = 1'b1; step(); step(); CS_Ins_load = 1'b0;
        check("ovr_err", err_overrun, 1);
        check("ovr_req", rom_req, 1);
        check("ovr_addr", rom_addr, 5);
        rom_ack = 1'b1; rom_data = 16'h0A40; step(); rom_ack = 1'b0; rom_data = 16'h0;
        check("ovr_valid", ins_valid, 1);
        step();
        check("ovr_idle", busy, 0);
        check_dec("ovr", 4'h0, 3'd5, 3'd1, 1'b0, 16'h1234);

        // Abort with en=0 during WAIT of an immediate fetch
        do_fetch(0, 16'hD5C0, 8'd5, "abort_pre");
        check("abort_pre_tb", two_byte, 1);
        CS_Ins_load = 1'b1; step(); CS_Ins_load = 1'b0;
        check("abort_wait_req", rom_req, 1);
        en = 1'b0; step();
        check("abort_req", rom_req, 0);
        check("abort_busy", busy, 0);
        check("abort_tb", two_byte, 0);
        check("abort_opcode_hold", opcode, 4'hD);
        en = 1'b1;
        do_fetch(1, 16'h0A40, 8'd5, "post_abort");
        check_dec("post_abort", 4'h0, 3'd5, 3'd1, 1'b0, 16'h1234);

        // Async reset mid-WAIT
        CS_PC_inc = 1'b1; step(); step(); CS_PC_inc = 1'b0;
        check("ar_pc_pre", pc, 2);
        CS_Ins_load = 1'b1; step(); CS_Ins_load = 1'b0;
        check("ar_req_pre", rom_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_req", rom_req, 0);
        check("ar_busy", busy, 0);
        check("ar_pc", pc, 0);
        check("ar_errs", {err_overrun, err_timeout}, 0);
        step();
        check("ar_no_valid", ins_valid, 0);
        #3 rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
